// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the writeback path.
package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NUM_REGS = 32;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   // One-hot register mask for a destination address.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [AW-1:0] addr);
      logic [NUM_REGS-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner and the first asserted request found gets the grant.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int N  = 2,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [LW-1:0] grant_idx,
   output logic          any_grant
);

   // Rotating priority search, lowest rotated offset first.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!any_grant && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx[LW-1:0];
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the single regfile write port among NUM_REQ
// writeback requesters, with one registered output stage feeding the
// regfile directly and a pending-write mask for hazard detection.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = regfile_pkg::XLEN,
   parameter int AW      = regfile_pkg::AW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*AW-1:0]   req_addr,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   output logic [AW-1:0]           rf_A3,
   output logic [XLEN-1:0]         rf_WD,
   output logic                    rf_We,
   output logic [31:0]             pending_mask,
   output logic [31:0]             grant_cnt
);

   localparam int LW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] grant;
   logic [LW-1:0]      grant_idx;
   logic               any_grant;
   logic [LW-1:0]      last_grant;

   logic [AW-1:0]      sel_addr_p0;
   logic [XLEN-1:0]    sel_data_p0;

   logic               vld_p1;
   logic [AW-1:0]      a3_p1;
   logic [XLEN-1:0]    wd_p1;
   logic [31:0]        cnt_p1;

   rr_arbiter #(
      .N  (NUM_REQ),
      .LW (LW)
   ) u_arb (
      .req       (req_valid),
      .last      (last_grant),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // The regfile drains every cycle, so ready is exactly the grant
   // (suppressed while reset is asserted).
   assign req_ready = rst_n ? grant : '0;

   // Stage 0: select address/data of the winning requester.
   always_comb begin
      sel_addr_p0 = '0;
      sel_data_p0 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr_p0 = req_addr[i*AW +: AW];
            sel_data_p0 = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Stage 1: output-stage registers, arbitration state and grant counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         a3_p1      <= '0;
         wd_p1      <= '0;
         cnt_p1     <= '0;
         last_grant <= LW'(NUM_REQ - 1);
      end else if (any_grant) begin
         // x0 writes are accepted and counted but never reach the regfile.
         vld_p1     <= (sel_addr_p0 != AW'(REG_ZERO));
         a3_p1      <= sel_addr_p0;
         wd_p1      <= sel_data_p0;
         cnt_p1     <= cnt_p1 + 32'd1;
         last_grant <= grant_idx;
      end else begin
         vld_p1     <= 1'b0;
      end
   end

   // The enable is qualified by rst_n so a reset arriving while a write is
   // staged discards it before the regfile can commit it on that edge.
   assign rf_We        = vld_p1 & rst_n;
   assign rf_A3        = a3_p1;
   assign rf_WD        = wd_p1;
   assign grant_cnt    = cnt_p1;
   assign pending_mask = rf_We ? 32'(reg_onehot(5'(rf_A3))) : 32'd0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int NUM_REQ = 2;
   localparam int XLEN    = 32;
   localparam int AW      = 5;

   logic                    clk;
   logic                    rst_n;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*AW-1:0]   req_addr;
   logic [NUM_REQ*XLEN-1:0] req_data;
   logic [AW-1:0]           rf_A3;
   logic [XLEN-1:0]         rf_WD;
   logic                    rf_We;
   logic [31:0]             pending_mask;
   logic [31:0]             grant_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] rf_model [32] = '{default: 32'd0};

   regfile_wb_arbiter #(
      .NUM_REQ (NUM_REQ),
      .XLEN    (XLEN),
      .AW      (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .rf_A3        (rf_A3),
      .rf_WD        (rf_WD),
      .rf_We        (rf_We),
      .pending_mask (pending_mask),
      .grant_cnt    (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file fed by the write port.
   always @(posedge clk) begin
      if (rf_We && rf_A3 != 5'd0)
         rf_model[rf_A3] <= rf_WD;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      req_addr[i*AW +: AW]     = a;
      req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      // Reset held two cycles with both requesters valid
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_addr  = '0;
      req_data  = '0;
      set_req(0, 5'd3, 32'hA);
      set_req(1, 5'd4, 32'hB);
      step();
      step();
      chk("rst_we",    {31'd0, rf_We}, 32'd0);
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_cnt",   grant_cnt, 32'd0);
      chk("rst_mask",  pending_mask, 32'd0);

      // Contention: req0 first after reset, then alternate
      rst_n = 1'b1;
      #1;
      chk("cont_ready0", {30'd0, req_ready}, 32'd1);
      step();
      chk("cont_we1",  {31'd0, rf_We}, 32'd1);
      chk("cont_a3_1", {27'd0, rf_A3}, 32'd3);
      chk("cont_wd_1", rf_WD, 32'hA);
      chk("cont_rdy1", {30'd0, req_ready}, 32'd2);
      chk("cont_cnt1", grant_cnt, 32'd1);
      step();
      chk("cont_a3_2", {27'd0, rf_A3}, 32'd4);
      chk("cont_wd_2", rf_WD, 32'hB);
      chk("cont_mask2", pending_mask, 32'h10);
      chk("cont_rdy2", {30'd0, req_ready}, 32'd1);
      chk("cont_cnt2", grant_cnt, 32'd2);
      step();
      chk("cont_a3_3", {27'd0, rf_A3}, 32'd3);
      chk("cont_cnt3", grant_cnt, 32'd3);
      req_valid = 2'b00;
      step();
      chk("idle_we",   {31'd0, rf_We}, 32'd0);
      chk("idle_a3",   {27'd0, rf_A3}, 32'd3);
      chk("idle_rdy",  {30'd0, req_ready}, 32'd0);
      chk("idle_cnt",  grant_cnt, 32'd3);

      // Single request from req0
      set_req(0, 5'd5, 32'h12345678);
      req_valid = 2'b01;
      #1;
      chk("single_rdy", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      chk("single_we",   {31'd0, rf_We}, 32'd1);
      chk("single_a3",   {27'd0, rf_A3}, 32'd5);
      chk("single_wd",   rf_WD, 32'h12345678);
      chk("single_mask", pending_mask, 32'h20);
      chk("single_cnt",  grant_cnt, 32'd4);
      step();
      chk("single_we_off",  {31'd0, rf_We}, 32'd0);
      chk("single_mask_off", pending_mask, 32'd0);
      chk("single_commit",  rf_model[5], 32'h12345678);

      // x0 write: accepted and counted, never written
      set_req(1, 5'd0, 32'hDEAD);
      req_valid = 2'b10;
      #1;
      chk("x0_rdy", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b00;
      chk("x0_we",   {31'd0, rf_We}, 32'd0);
      chk("x0_mask", pending_mask, 32'd0);
      chk("x0_cnt",  grant_cnt, 32'd5);

      // Same-destination race on r7: req0 wins first (last was req1)
      set_req(0, 5'd7, 32'h1);
      set_req(1, 5'd7, 32'h2);
      req_valid = 2'b11;
      #1;
      chk("race_rdy0", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b10;
      chk("race_wd1", rf_WD, 32'h1);
      chk("race_a3",  {27'd0, rf_A3}, 32'd7);
      step();
      req_valid = 2'b00;
      chk("race_wd2",    rf_WD, 32'h2);
      chk("race_r7_one", rf_model[7], 32'h1);
      step();
      chk("race_r7_two", rf_model[7], 32'h2);
      chk("race_cnt",    grant_cnt, 32'd7);

      // Reset on the cycle after a grant discards the staged write
      set_req(0, 5'd9, 32'h99);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      chk("mid_we_staged", {31'd0, rf_We}, 32'd1);
      chk("mid_a3",        {27'd0, rf_A3}, 32'd9);
      rst_n = 1'b0;
      step();
      chk("mid_we_off", {31'd0, rf_We}, 32'd0);
      chk("mid_r9",     rf_model[9], 32'd0);
      chk("mid_cnt",    grant_cnt, 32'd0);
      // Last winner was req0; after reset priority restarts at req0
      set_req(0, 5'd1, 32'h11);
      set_req(1, 5'd2, 32'h22);
      req_valid = 2'b11;
      rst_n = 1'b1;
      #1;
      chk("mid_prio", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      chk("mid_post_a3",  {27'd0, rf_A3}, 32'd1);
      chk("mid_post_cnt", grant_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
